// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first over WIDTH cycles and
// reports result, borrow, zero and signed overflow with a start/ready/out_valid handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  // Handshake: an operation is accepted at a rising edge where start=1 and
  // ready=1; out_valid pulses for exactly one cycle when result/flags update,
  // and ready is high again in that same cycle so a new start can be accepted.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             brw;
  logic             a_msb;
  logic             b_msb;

  logic             d_bit;
  logic             brw_nxt;
  logic             last;
  logic [WIDTH-1:0] final_val;

  // One full-subtractor bit slice plus the value the result register will hold.
  always_comb begin
    d_bit     = a_sr[0] ^ b_sr[0] ^ brw;
    brw_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    final_val = {d_bit, d_sr[WIDTH-1:1]};
    last      = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // Datapath: shift registers, serial borrow and the held output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      d_sr      <= '0;
      brw       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            d_sr  <= '0;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= final_val;
          brw  <= brw_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            result    <= final_val;
            borrow    <= brw_nxt;
            zero      <= (final_val == '0);
            overflow  <= (a_msb != b_msb) && (final_val[WIDTH-1] != a_msb);
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
